// File: rtl/expr_pkg.sv
// Shared definitions for the expression stream: FSM states and ASCII codes,
// common to the transmitter and the expr recognizer.
package expr_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIGIT = 2'd1,
        S_OP    = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CH_0    = 8'd48;
    localparam logic [7:0] CH_9    = 8'd57;
    localparam logic [7:0] CH_PLUS = 8'd43;
    localparam logic [7:0] CH_STAR = 8'd42;

    // A BCD nibble is legal when its ASCII form lands inside '0'..'9'.
    function automatic logic digit_ok(input logic [3:0] d);
        logic [7:0] ch;
        ch = CH_0 + {4'd0, d};
        return (ch <= CH_9);
    endfunction

endpackage

// File: rtl/expr_tx_if.sv
// Request/stream bundle between the command source, expr_tx and the consumer.
interface expr_tx_if #(
    parameter int MAX_TERMS = 8,
    parameter int NW        = $clog2(MAX_TERMS + 1)
);
    localparam int OPW = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

    logic                     load;
    logic [4*MAX_TERMS-1:0]   digits;
    logic [OPW-1:0]           ops;
    logic [NW-1:0]            nterms;
    logic                     ready;
    logic [7:0]               out;
    logic                     out_valid;
    logic                     busy;
    logic                     done;
    logic                     err;

    // Transmitter side: takes the request and the downstream ready.
    modport master (
        input  load, digits, ops, nterms, ready,
        output out, out_valid, busy, done, err
    );

    // Source/consumer side.
    modport slave (
        output load, digits, ops, nterms, ready,
        input  out, out_valid, busy, done, err
    );
endinterface

// File: rtl/expr_char_enc.sv
// Maps one stream element (digit or operator) onto its ASCII byte.
module expr_char_enc
    import expr_pkg::*;
(
    input  logic       is_op_i,
    input  logic [3:0] digit_i,
    input  logic       op_i,
    output logic [7:0] ch_o
);

    // Operator bit 1 selects '*', 0 selects '+'; digits are offset from '0'.
    always_comb begin
        ch_o = 8'd0;
        if (is_op_i) begin
            ch_o = op_i ? CH_STAR : CH_PLUS;
        end else begin
            ch_o = CH_0 + {4'd0, digit_i};
        end
    end

endmodule

// File: rtl/expr_tx.sv
// Expression transmitter: validates a parallel expression, latches it and
// serialises it as digit (op digit)* over a valid/ready stream.
module expr_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int NW        = $clog2(MAX_TERMS + 1)
) (
    input  logic      clk,
    input  logic      clr,
    expr_tx_if.master bus
);

    localparam int OPW = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;
    localparam int DW  = 4 * MAX_TERMS;

    state_t            state_q, state_d;
    logic [NW-1:0]     idx_q, idx_d;
    logic [NW-1:0]     nterms_q, nterms_d;
    logic [DW-1:0]     digits_q, digits_d;
    logic [OPW-1:0]    ops_q, ops_d;
    logic              err_q, err_d;
    logic [7:0]        out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              digits_ok_s;
    logic              count_ok_s;
    logic              load_ok_s;
    logic              xfer_s;
    logic [DW-1:0]     digits_sh_s;
    logic [OPW-1:0]    ops_sh_s;
    logic [7:0]        enc_ch_s;

    // Request check: count in 1..MAX_TERMS and every active digit is BCD.
    always_comb begin
        digits_ok_s = 1'b1;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((NW'(i) < bus.nterms) && !digit_ok(bus.digits[4*i +: 4])) begin
                digits_ok_s = 1'b0;
            end else begin
                digits_ok_s = digits_ok_s;
            end
        end
        count_ok_s = (bus.nterms != {NW{1'b0}}) && (bus.nterms <= NW'(MAX_TERMS));
        load_ok_s  = digits_ok_s & count_ok_s;
    end

    assign xfer_s = out_valid_q & bus.ready;

    // Next-state logic: walks DIGIT/OP on each transfer, latches on load.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nterms_d = nterms_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    if (load_ok_s) begin
                        nterms_d = bus.nterms;
                        digits_d = bus.digits;
                        ops_d    = bus.ops;
                        idx_d    = {NW{1'b0}};
                        state_d  = S_DIGIT;
                    end else begin
                        err_d    = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIGIT: begin
                if (xfer_s) begin
                    if (idx_q == (nterms_q - NW'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_OP;
                    end
                end else begin
                    state_d = S_DIGIT;
                end
            end
            S_OP: begin
                if (xfer_s) begin
                    idx_d   = idx_q + NW'(1);
                    state_d = S_DIGIT;
                end else begin
                    state_d = S_OP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select the current term/operator from the next-cycle latched data.
    always_comb begin
        digits_sh_s = digits_d >> {idx_d, 2'b00};
        ops_sh_s    = ops_d >> idx_d;
    end

    expr_char_enc u_enc (
        .is_op_i (state_d == S_OP),
        .digit_i (digits_sh_s[3:0]),
        .op_i    (ops_sh_s[0]),
        .ch_o    (enc_ch_s)
    );

    // Output decode for the next cycle so every output leaves a flop.
    always_comb begin
        out_valid_d = (state_d == S_DIGIT) || (state_d == S_OP);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        if (out_valid_d) begin
            out_d = enc_ch_s;
        end else begin
            out_d = 8'd0;
        end
    end

    // State, latched request and registered outputs; clr drops them at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            idx_q       <= {NW{1'b0}};
            nterms_q    <= {NW{1'b0}};
            digits_q    <= {DW{1'b0}};
            ops_q       <= {OPW{1'b0}};
            err_q       <= 1'b0;
            out_q       <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nterms_q    <= nterms_d;
            digits_q    <= digits_d;
            ops_q       <= ops_d;
            err_q       <= err_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: expected bytes are queued when a load is
// driven and compared as the stream is consumed.
module tb_expr_tx;

    localparam int MT = 8;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_q[$];

    expr_tx_if #(.MAX_TERMS(MT)) bus ();

    expr_tx #(.MAX_TERMS(MT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one edge and queue the bytes it must produce.
    task automatic load_expr(input logic [3:0] nt, input logic [31:0] dg, input logic [6:0] op);
        bus.nterms = nt;
        bus.digits = dg;
        bus.ops    = op;
        bus.load   = 1'b1;
        for (int i = 0; i < int'(nt); i++) begin
            exp_q.push_back(8'd48 + {4'd0, dg[4*i +: 4]});
            if (i < int'(nt) - 1) begin
                exp_q.push_back(op[i] ? 8'h2A : 8'h2B);
            end
        end
        step();
        bus.load = 1'b0;
    endtask

    // Consume the stream; optional stall at byte stall_idx and a stray load
    // with altered inputs at byte glitch_idx.
    task automatic run_stream(input int stall_idx, input int stall_n,
                              input int glitch_idx, input int exp_cycles);
        int nbytes;
        int cyc;
        int stall_left;
        bit seen_done;
        nbytes = 0;
        cyc = 0;
        stall_left = stall_n;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            cyc++;
            if (bus.done) begin
                seen_done = 1'b1;
                check("queue_empty_at_done", exp_q.size(), 0);
                check("done_cycle", cyc, exp_cycles);
                check("out_in_done", {24'd0, bus.out}, 32'd0);
                check("valid_in_done", {31'd0, bus.out_valid}, 32'd0);
                bus.load = 1'b0;
                bus.ready = 1'b1;
            end else begin
                check("out_valid", {31'd0, bus.out_valid}, 32'd1);
                check("busy", {31'd0, bus.busy}, 32'd1);
                check("no_err", {31'd0, bus.err}, 32'd0);
                if (exp_q.size() > 0) begin
                    check("byte", {24'd0, bus.out}, {24'd0, exp_q[0]});
                end else begin
                    check("extra_byte", 32'd1, 32'd0);
                end
                if (nbytes == stall_idx && stall_left > 0) begin
                    bus.ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.ready = 1'b1;
                end
                if (nbytes == glitch_idx) begin
                    bus.load   = 1'b1;
                    bus.digits = 32'h12345678;
                    bus.ops    = 7'h55;
                    bus.nterms = 4'd1;
                end else begin
                    bus.load = 1'b0;
                end
                if (bus.ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    nbytes++;
                end
                step();
            end
        end
        if (!seen_done) begin
            check("done_timeout", 32'd0, 32'd1);
        end
        step();
        check("idle_done_low", {31'd0, bus.done}, 32'd0);
        check("idle_busy_low", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic reject(input string tag, input logic [3:0] nt, input logic [31:0] dg);
        bus.nterms = nt;
        bus.digits = dg;
        bus.ops    = 7'd0;
        bus.load   = 1'b1;
        step();
        bus.load = 1'b0;
        check({tag, "_err"}, {31'd0, bus.err}, 32'd1);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        step();
        check({tag, "_err_drop"}, {31'd0, bus.err}, 32'd0);
        check({tag, "_busy2"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clr        = 1'b1;
        bus.load   = 1'b0;
        bus.digits = 32'd0;
        bus.ops    = 7'd0;
        bus.nterms = 4'd0;
        bus.ready  = 1'b1;

        #2;
        check("rst_out", {24'd0, bus.out}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        #11;
        clr = 1'b0;
        step();

        // Single term.
        load_expr(4'd1, 32'h00000007, 7'd0);
        run_stream(-1, 0, -1, 2);

        // Three terms 1+2*3.
        load_expr(4'd3, 32'h00000321, 7'b0000010);
        run_stream(-1, 0, -1, 6);

        // Same, with 0x2B held for three stalled cycles.
        load_expr(4'd3, 32'h00000321, 7'b0000010);
        run_stream(1, 3, -1, 9);

        // Digits beyond nterms are don't-care.
        load_expr(4'd2, 32'hFFFFFF45, 7'd0);
        run_stream(-1, 0, -1, 4);

        // Rejected requests.
        reject("rej_n0", 4'd0, 32'h00000001);
        reject("rej_n9", 4'd9, 32'h11111111);
        reject("rej_digit10", 4'd3, 32'h000003A1);

        // Asynchronous clear during the third byte.
        load_expr(4'd3, 32'h00000321, 7'b0000010);
        step();
        step();
        check("pre_clr_byte3", {24'd0, bus.out}, 32'h32);
        #2;
        clr = 1'b1;
        #1;
        check("clr_valid", {31'd0, bus.out_valid}, 32'd0);
        check("clr_busy", {31'd0, bus.busy}, 32'd0);
        check("clr_out", {24'd0, bus.out}, 32'd0);
        #1;
        clr = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            step();
            check("clr_no_done", {31'd0, bus.done}, 32'd0);
            check("clr_stays_idle", {31'd0, bus.out_valid}, 32'd0);
        end
        load_expr(4'd3, 32'h00000654, 7'b0000001);
        run_stream(-1, 0, -1, 6);

        // Full width, all '9' and '*', with a stray load mid-stream.
        load_expr(4'd8, 32'h99999999, 7'h7F);
        run_stream(-1, 0, 4, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
